// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: per-stage payload structs, stall source indices and
// the handshake state encoding used by pipe_stage_reg.
package cpu_pipe_pkg;

  localparam int STALL_DM      = 0;
  localparam int STALL_WFI     = 1;
  localparam int NUM_STALL_SRC = 2;

  // Encoding is {main valid, skid valid} so the bits drive outputs directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
  } mem_wb_payload_t;

  function automatic logic [NUM_STALL_SRC-1:0] stall_vec(input logic dm_wait,
                                                         input logic wfi);
    logic [NUM_STALL_SRC-1:0] v;
    v            = '0;
    v[STALL_DM]  = dm_wait;
    v[STALL_WFI] = wfi;
    return v;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Count updates one cycle after i_inc/i_clr.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid entry, stall inputs and flush.
// One-cycle latency; SKID=1 keeps ready registered, SKID=0 ready depends on downstream.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_STALL      = 2,
  parameter int SKID           = 1,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_FLUSH = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATA_W-1:0]    i_data,
  output logic                 o_in_ready,
  output logic                 o_valid,
  output logic [DATA_W-1:0]    o_data,
  input  logic                 i_out_ready,
  input  logic [NUM_STALL-1:0] i_stall,
  input  logic                 i_flush,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic stall_any, rdy_eff, out_fire, in_fire, skid_vld;

  assign stall_any = |i_stall;
  assign rdy_eff   = i_out_ready & ~stall_any;
  assign o_valid   = state_q[1];
  assign skid_vld  = state_q[0];
  assign out_fire  = o_valid & rdy_eff;
  assign in_fire   = i_valid & o_in_ready;

  // Ready is forced high during flush so upstream never waits on a dying stage.
  always_comb begin
    o_in_ready = 1'b1;
    if (!i_flush) begin
      if (SKID != 0) o_in_ready = ~skid_vld;
      else           o_in_ready = ~o_valid | rdy_eff;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = i_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            // Only reachable with SKID=1; SKID=0 accepts only while draining.
            state_d = ST_FULL;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_data = main_q;

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(i_cnt_clr),
    .i_inc(o_valid & ~rdy_eff & ~i_flush),
    .o_cnt(o_stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage CPU pipeline registers.
- Carries a generic packed payload between two pipeline stages with a valid/ready handshake.
- Accepts N independent stall sources and a flush that kills in-flight beats.
- Optional one-entry skid buffer gives full throughput under backpressure, plus a saturating stall-cycle counter for performance monitoring.
- Instantiated between IF/ID/EX/MEM/WB stages in place of hand-written per-stage registers.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- NUM_STALL, 2, number of stall request inputs (>=1).
- SKID, 1, 1 = two-entry (main + skid) buffering, 0 = single register with combinational ready path.
- CNT_W, 16, width of stall-cycle counter.
- CLEAR_ON_FLUSH, 0, 1 = payload registers also zeroed on flush.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream beat valid.
- i_data  in  DATA_W  upstream payload.
- o_in_ready  out  1  stage can accept upstream beat this cycle.
- o_valid  out  1  downstream beat valid (registered).
- o_data  out  DATA_W  downstream payload (registered).
- i_out_ready  in  1  downstream accepts beat.
- i_stall  in  NUM_STALL  stall requests (e.g. DM wait, WFI); any bit set freezes output.
- i_flush  in  1  kill all held beats.
- i_cnt_clr  in  1  synchronous clear of stall counter.
- o_stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: o_valid=0, o_data=0, skid valid=0, skid data=0, o_stall_cnt=0; o_in_ready follows the rules below once skid valid=0.
- stall_any = OR of i_stall. rdy_eff = i_out_ready & ~stall_any. out_fire = o_valid & rdy_eff. in_fire = i_valid & o_in_ready.
- Latency: accepted beat appears on o_valid/o_data the next cycle when the main register is empty or draining.
- SKID=1, o_in_ready = ~skid_valid (registered, no comb path from i_out_ready). State machine on {o_valid, skid_valid}:
  - EMPTY: in_fire -> ONE, main <= i_data.
  - ONE: in_fire & out_fire -> ONE, main <= i_data. in_fire & ~out_fire -> FULL, skid <= i_data. ~in_fire & out_fire -> EMPTY.
  - FULL: o_in_ready=0. out_fire -> ONE, main <= skid.
- SKID=0: o_in_ready = ~o_valid | rdy_eff. in_fire loads main. out_fire without in_fire clears o_valid.
- Ordering: beats leave in acceptance order, never duplicated, never dropped except on flush.
- Flush has priority over stall, handshake and in_fire:
  - Next cycle o_valid=0, skid_valid=0.
  - A beat presented in the flush cycle is discarded; o_in_ready is forced to 1 during flush so upstream does not hang.
  - Payload registers hold their value unless CLEAR_ON_FLUSH=1, in which case they are zeroed.
- Stall with i_out_ready=1: output frozen, same as backpressure. Upstream may still fill skid when SKID=1.
- Stall counter:
  - Increments by 1 each cycle o_valid & ~rdy_eff & ~i_flush.
  - Saturates at 2^CNT_W-1.
  - i_cnt_clr sets it to 0 and wins over increment.
  - Not affected by flush.
- Reset asserted mid-operation: all state cleared immediately (asynchronous); no beat survives.

Decomposition:
- Shared package cpu_pipe_pkg holds the per-stage payload struct typedefs (e.g. mem_wb_payload_t) and stall-index localparams (STALL_DM, STALL_WFI). Instantiators pack structs into i_data.
- Natural sub-module: pipe_stall_counter (saturating counter with clear), reused by other perf-monitor blocks.
- Handshake core stays in pipe_stage_reg.

Test Plan:
- Pass-through: SKID=1, i_out_ready=1, stream 0xA0..0xA7 back-to-back -> o_data shows 0xA0..0xA7 on consecutive cycles, 1-cycle latency, o_stall_cnt=0.
- Backpressure: send 0x11, 0x22, 0x33 with i_out_ready=0 -> after 0x22 accepted o_in_ready=0 and 0x33 held upstream. Release i_out_ready -> output order 0x11, 0x22, 0x33; o_stall_cnt counts the held cycles exactly.
- Stall vector: NUM_STALL=2, i_stall=2'b10 for 3 cycles with o_valid=1 and i_out_ready=1 -> o_data frozen, o_stall_cnt += 3, no beat lost.
- Flush while FULL with i_valid=1 (0x55) -> next cycle o_valid=0, skid empty, 0x55 not delivered. With CLEAR_ON_FLUSH=1, o_data=0.
- Saturation/clear: CNT_W=4, stall 20 cycles -> o_stall_cnt=15. i_cnt_clr concurrent with stall -> 0.
- SKID=0: i_out_ready toggling 1/0 each cycle -> o_in_ready equals ~o_valid | i_out_ready combinationally. Async reset pulse mid-stream -> o_valid=0 and o_stall_cnt=0 before the next clock edge.
